// File: rtl/forward_unit.sv
// forward_unit
//   Operand-forwarding and load-use hazard detection for a 5-stage in-order
//   pipeline. Tracks {valid, rd, we, load} tags for the instructions in EX,
//   MEM and WB. From these tags it computes registered 3:1 mux selects for
//   the two EX operands. It also flags a combinational stall when the ID
//   instruction reads the destination of a load still in EX.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   id_valid    ID-stage instruction valid
//   id_rs       ID source register A
//   id_rt       ID source register B
//   id_uses_rt  ID instruction actually reads id_rt
//   id_rd       ID destination register
//   id_we       ID instruction writes id_rd
//   id_load     ID instruction is a load
//   flush       taken branch; kill what would enter EX
//   fwd_sel_a   EX operand-A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   fwd_sel_b   EX operand-B select, same encoding
//   stall       load-use hazard; hold PC and IF/ID
module forward_unit #(
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          flush,
    output logic [1:0]    fwd_sel_a,
    output logic [1:0]    fwd_sel_b,
    output logic          stall
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          we;
        logic          load;
    } tag_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // Tag pipeline: index 0 = EX, 1 = MEM, 2 = WB. The WB tag is never a
    // forwarding source because the register file is assumed to be
    // write-first. It is still tracked so the tag pipeline mirrors the
    // datapath stage for stage.
    tag_t tag_reg [3];

    logic [1:0] fwd_sel_a_reg;
    logic [1:0] fwd_sel_b_reg;

    // Operand 0 is rs (always read), operand 1 is rt (read only if id_uses_rt).
    logic [1:0][RW-1:0] src;
    logic [1:0]         use_op;
    logic [1:0]         ex_hit;
    logic [1:0]         mem_hit;
    logic [1:0]         load_hit;
    logic [1:0][1:0]    sel_next;
    logic               advance;

    assign src[0] = id_rs;
    assign src[1] = id_rt;
    assign use_op = {id_uses_rt, 1'b1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_op
            // Register 0 is hard-wired zero: it never matches a producer.
            assign ex_hit[gi]   = use_op[gi] && (src[gi] != '0)
                                  && tag_reg[EX].valid && tag_reg[EX].we
                                  && (tag_reg[EX].rd == src[gi]);
            assign mem_hit[gi]  = use_op[gi] && (src[gi] != '0)
                                  && tag_reg[MEM].valid && tag_reg[MEM].we
                                  && (tag_reg[MEM].rd == src[gi]);
            // A load in EX has no data yet, so a match there cannot be bypassed.
            assign load_hit[gi] = ex_hit[gi] && tag_reg[EX].load;
            // The youngest producer (EX) wins over the older one (MEM).
            assign sel_next[gi] = ex_hit[gi]  ? 2'b01 :
                                  mem_hit[gi] ? 2'b10 : 2'b00;
        end
    endgenerate

    // Flush dominates. The instruction is being killed, so it must not hold
    // the front end.
    assign stall   = id_valid && !flush && (|load_hit);
    assign advance = !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                tag_reg[i] <= '0;
            end
            fwd_sel_a_reg <= 2'b00;
            fwd_sel_b_reg <= 2'b00;
        end else begin
            // MEM and WB always advance; only EX can receive a bubble.
            for (int i = 1; i < 3; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            tag_reg[EX].valid <= advance && id_valid;
            tag_reg[EX].rd    <= id_rd;
            tag_reg[EX].we    <= id_we;
            tag_reg[EX].load  <= id_load;
            if (advance && id_valid) begin
                fwd_sel_a_reg <= sel_next[0];
                fwd_sel_b_reg <= sel_next[1];
            end else begin
                fwd_sel_a_reg <= 2'b00;
                fwd_sel_b_reg <= 2'b00;
            end
        end
    end

    assign fwd_sel_a = fwd_sel_a_reg;
    assign fwd_sel_b = fwd_sel_b_reg;

endmodule

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 Parameters SHALL be: RW, default 3, register-index width (8 architectural registers).
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID-stage instruction valid
- id_rs  input  RW  ID source register A
- id_rt  input  RW  ID source register B
- id_uses_rt  input  1  ID instruction reads id_rt
- id_rd  input  RW  ID destination register
- id_we  input  1  ID instruction writes id_rd
- id_load  input  1  ID instruction is a load
- flush  input  1  taken branch; kill ID/EX contents
- fwd_sel_a  output  2  EX operand-A 3:1 mux select
- fwd_sel_b  output  2  EX operand-B 3:1 mux select
- stall  output  1  load-use hazard; hold PC and IF/ID
REQ-003 The design SHALL use a single clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Select encoding SHALL be 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result; 11 SHALL never be driven.
REQ-005 The block SHALL hold three internal tag stages, EX, MEM and WB, each holding {valid, rd, we, load}.
REQ-006 A stage SHALL be a "writer of r" when its valid=1, we=1, rd=r and r!=0; register 0 SHALL never be forwarded or cause a stall.
REQ-007 stall SHALL be combinational: id_valid & ~flush & (EX is a load writer of id_rs, or id_uses_rt=1 and EX is a load writer of id_rt).
REQ-008 On every clock edge, MEM SHALL be loaded from EX and WB SHALL be loaded from MEM, unconditionally.
REQ-009 On an edge with flush=0 and stall=0, EX SHALL be loaded from the ID inputs, with valid=id_valid.
REQ-010 On an edge with stall=1 or flush=1, EX SHALL be loaded with a bubble (valid=0), and fwd_sel_a and fwd_sel_b SHALL be loaded with 00.
REQ-011 Otherwise, fwd_sel_a SHALL register 01 if the pre-edge EX is a writer of id_rs; else 10 if the pre-edge MEM is a writer of id_rs; else 00.
REQ-012 fwd_sel_b SHALL follow the same rule for id_rt, gated by id_uses_rt (00 when id_uses_rt=0). The youngest producer, EX/MEM, SHALL have priority.
REQ-013 fwd_sel_a and fwd_sel_b SHALL be registered and valid in the cycle the instruction occupies EX, with 1-cycle latency from ID.
REQ-014 A stalled ID instruction SHALL be re-presented by the core on the next cycle. Its forwarding SHALL then resolve against the load now in MEM and SHALL yield 10.
REQ-015 flush SHALL take priority over stall; stall SHALL be 0 while flush=1.
REQ-016 When both operands match different stages, each select SHALL be resolved independently.
REQ-017 When id_valid=0 and flush=0, the selects SHALL register 00 and EX SHALL capture a bubble.

Reset
REQ-018 rst_n=0 SHALL immediately clear the EX, MEM and WB valid bits and drive fwd_sel_a=00 and fwd_sel_b=00, regardless of clk.
REQ-019 Because all valid bits are cleared, stall SHALL read 0 while rst_n=0.
REQ-020 Reset asserted mid-stall SHALL drop stall in the same cycle. The first post-reset instruction SHALL see no forwarding.

Verification
REQ-021 The bench SHALL cover ALU back-to-back: cycle0 ID {rd=3, we=1}; cycle1 ID {rs=3, rt=5, uses_rt=1} -> cycle2 fwd_sel_a=01, fwd_sel_b=00, stall=0.
REQ-022 The bench SHALL cover distance-2 forwarding plus priority:
- writer r2 in cycle0, writer r2 in cycle1, reader rs=2 in cycle2 -> fwd_sel_a=01.
- with the cycle1 writer removed -> fwd_sel_a=10.
REQ-023 The bench SHALL cover load-use: cycle0 load {rd=4}; cycle1 reader rt=4, uses_rt=1 -> stall=1 in cycle1, fwd_sel_b=00 in cycle2; reader re-presented in cycle2 -> stall=0, cycle3 fwd_sel_b=10.
REQ-024 The bench SHALL cover register 0: writer rd=0 followed by reader rs=0, rt=0 -> selects 00 and stall=0.
REQ-025 The bench SHALL cover flush precedence: load {rd=6}, then reader rs=6 with flush=1 -> stall=0, EX bubble, next-cycle selects 00.
REQ-026 The bench SHALL cover reset mid-operation: drop rst_n asynchronously while stall=1 -> stall and selects read 0 before the next clk edge, and the post-reset reader of r4 gets 00.
